// File: rtl/mem_pkg.sv
// Shared types and widths for the data memory responder and its SRAM array.
package mem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

endpackage

// File: rtl/data_mem_array.sv
// Single-port word SRAM with per-byte write enables and a registered read port.
module data_mem_array
    import mem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    IDX_W       = $clog2(DEPTH_WORDS),
    parameter string INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Read data only moves on a read access, so it holds for the whole response window.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/data_mem_resp.sv
// Memory-side responder for the core data interface: one outstanding request,
// response returned a fixed LATENCY cycles after the grant edge.
module data_mem_resp
    import mem_pkg::*;
#(
    parameter int                DEPTH_WORDS = 1024,
    parameter int                LATENCY     = 1,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter string             INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_req_i,
    input  logic [ADDR_W-1:0] data_add_i,
    input  logic              data_we_i,
    input  logic [BE_W-1:0]   data_be_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_err_o,
    output resp_state_t       dbg_state
);

    localparam int                IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0]   SPAN     = (ADDR_W+1)'(DEPTH_WORDS) << 2;
    localparam logic [2:0]        CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("data_mem_resp: LATENCY must be within 1..8");
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("data_mem_resp: DEPTH_WORDS must be a power of two");
    end

    resp_state_t       state, state_n;
    logic [2:0]        cnt, cnt_n;
    logic              hs;
    logic [ADDR_W-1:0] off;
    logic              in_range;
    logic              resp_read_q;
    logic              err_q;
    logic [DATA_W-1:0] arr_rdata;

    // Addresses below BASE_ADDR wrap to a large offset and fail the same compare.
    assign off      = data_add_i - BASE_ADDR;
    assign in_range = {1'b0, off} < SPAN;

    // Valid/ready: a request is accepted on an edge where req and gnt are both high;
    // request fields are sampled only on that edge. gnt is also open in RESP so a
    // new request can be accepted while the previous response is presented.
    assign data_gnt_o = data_req_i & ~rst & (state == IDLE || state == RESP);
    assign hs         = data_req_i & data_gnt_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE, RESP: begin
                if (hs) begin
                    if (LATENCY == 1) begin
                        state_n = RESP;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CNT_INIT;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            WAIT: begin
                if (cnt == 3'd0) state_n = RESP;
                else             cnt_n   = cnt - 3'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        data_rvalid_o = (state == RESP);
        dbg_state     = state;
        data_err_o    = err_q;
        data_rdata_o  = resp_read_q ? arr_rdata : '0;
    end

    // Response kind is latched at the grant; write and out-of-range responses return zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_read_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (hs) begin
            resp_read_q <= ~data_we_i & in_range;
            err_q       <= ~in_range;
        end
    end

    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W),
        .INIT_FILE   (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .en    (hs & in_range),
        .we    (data_we_i),
        .idx   (off[IDX_W+1:2]),
        .be    (data_be_i),
        .wdata (data_wdata_i),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: a LATENCY=1 and a LATENCY=3 instance share the request
// bus (sel steers req), responses are checked against a word-map reference model.
module tb_data_mem_resp;
    import mem_pkg::*;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam longint      SPAN  = 4 * DEPTH;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req = 1'b0, sel = 1'b0, we = 1'b0;
    logic [31:0] add = '0, wdata = '0;
    logic [3:0]  be = '0;

    logic        gnt1, rv1, err1, gnt3, rv3, err3;
    logic [31:0] rd1, rd3;
    resp_state_t st1, st3;

    data_mem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(BASE), .INIT_FILE("")) u_l1 (
        .clk(clk), .rst(rst), .data_req_i(req & ~sel), .data_add_i(add), .data_we_i(we),
        .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(gnt1), .data_rvalid_o(rv1),
        .data_rdata_o(rd1), .data_err_o(err1), .dbg_state(st1)
    );

    data_mem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(3), .BASE_ADDR(BASE), .INIT_FILE("")) u_l3 (
        .clk(clk), .rst(rst), .data_req_i(req & sel), .data_add_i(add), .data_we_i(we),
        .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(gnt3), .data_rvalid_o(rv3),
        .data_rdata_o(rd3), .data_err_o(err3), .dbg_state(st3)
    );

    // scoreboard state
    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q0[$], exp_q1[$];
    int          g_q0[$], g_q1[$];
    logic [31:0] m0[int], m1[int];
    bit          chained = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + SPAN);
    endfunction

    // Reference: word map keyed by word index; response is {err, rdata}.
    task automatic model(input bit s, input bit w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, output logic [32:0] resp);
        int          idx;
        logic [31:0] word;
        if (!in_rng(a)) begin
            resp = {1'b1, 32'h0};
        end else begin
            idx  = int'((longint'(a) - longint'(BASE)) / 4);
            word = s ? (m1.exists(idx) ? m1[idx] : 32'h0) : (m0.exists(idx) ? m0[idx] : 32'h0);
            if (w) begin
                for (int i = 0; i < 4; i++) if (b[i]) word[8*i +: 8] = d[8*i +: 8];
                if (s) m1[idx] = word; else m0[idx] = word;
                resp = {1'b0, 32'h0};
            end else begin
                resp = {1'b0, word};
            end
        end
    endtask

    // driver: holds req until granted, records expectation at the grant
    task automatic issue(input bit s, input bit w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input int exp_wait);
        int          waited = 0;
        bit          done = 0;
        logic [32:0] r;
        sel = s; req = 1'b1; we = w; add = a; be = b; wdata = d;
        while (!done) begin
            @(negedge clk);
            if (s ? gnt3 : gnt1) begin
                model(s, w, a, b, d, r);
                if (s) begin exp_q1.push_back(r); g_q1.push_back(cyc + 1); end
                else   begin exp_q0.push_back(r); g_q0.push_back(cyc + 1); end
                if (exp_wait >= 0) check("grant_wait", 64'(waited), 64'(exp_wait));
                done = 1;
            end else if (waited >= 40) begin
                checks++; errors++;
                $display("FAIL grant_timeout: got no grant expected grant within 40 cycles");
                done = 1;
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
        req = 1'b0;
    endtask

    task automatic op(input bit s, input bit w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d);
        issue(s, w, a, b, d, chained ? (s ? 2 : 0) : 0);
        chained = 1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0", exp_q0.size(), exp_q1.size());
            exp_q0.delete(); exp_q1.delete(); g_q0.delete(); g_q1.delete();
        end
        @(posedge clk); #1;
        chained = 0;
    endtask

    // monitor
    task automatic mon(input bit s, input logic rv, input logic [31:0] rd, input logic e);
        logic [32:0] r;
        int          g;
        if (rv === 1'b1) begin
            if ((s ? exp_q1.size() : exp_q0.size()) == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rvalid: got rvalid on L%0d expected none", s ? 3 : 1);
            end else begin
                if (s) begin r = exp_q1.pop_front(); g = g_q1.pop_front(); end
                else   begin r = exp_q0.pop_front(); g = g_q0.pop_front(); end
                check(s ? "rdata_l3" : "rdata_l1", 64'(rd), 64'(r[31:0]));
                check(s ? "err_l3" : "err_l1", 64'(e), 64'(r[32]));
                check(s ? "latency_l3" : "latency_l1", 64'(cyc - g), s ? 64'd2 : 64'd0);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(1'b0, rv1, rd1, err1);
        mon(1'b1, rv3, rd3, err3);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by 500us");
        $fatal(1);
    end

    logic [31:0] pool[7];

    initial begin
        pool[0] = BASE;            pool[1] = BASE + 32'h10;  pool[2] = BASE + 32'h20;
        pool[3] = BASE + 32'h3FC;  pool[4] = BASE + 32'(SPAN);
        pool[5] = BASE - 32'h4;    pool[6] = 32'hFFFF_FFFC;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_outputs", 64'({gnt1, gnt3, rv1, rv3, err1, err3}), 64'd0);
        end
        @(posedge clk); #1;

        for (int s = 0; s < 2; s++) begin
            // known contents for every in-range pool word
            for (int k = 0; k < 4; k++) op(s[0], 1'b1, pool[k], 4'hF, $urandom);
            drain();
            // full write then read-after-write
            op(s[0], 1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF);
            op(s[0], 1'b0, BASE + 32'h10, 4'h0, 32'h0);
            drain();
            // partial write
            op(s[0], 1'b1, BASE + 32'h20, 4'hF, 32'h1122_3344);
            op(s[0], 1'b1, BASE + 32'h20, 4'b0101, 32'hAABB_CCDD);
            op(s[0], 1'b0, BASE + 32'h20, 4'hF, 32'h0);
            op(s[0], 1'b1, BASE + 32'h20, 4'h0, 32'hFFFF_FFFF);
            op(s[0], 1'b0, BASE + 32'h20, 4'h3, 32'h0);
            drain();
            // out of range write/read, word 0 untouched
            op(s[0], 1'b1, BASE + 32'(SPAN), 4'hF, 32'h5555_AAAA);
            op(s[0], 1'b0, BASE + 32'(SPAN), 4'hF, 32'h0);
            op(s[0], 1'b0, BASE, 4'hF, 32'h0);
            drain();
            // req held across back-to-back reads
            for (int k = 0; k < 4; k++) op(s[0], 1'b0, BASE + 32'h20, 4'hF, 32'h0);
            drain();
            // randomized traffic over the pool, low address bits randomized
            for (int k = 0; k < 40; k++) begin
                op(s[0], 1'($urandom_range(0, 1)), pool[$urandom_range(0, 6)] | 32'($urandom_range(0, 3)),
                   4'($urandom_range(0, 15)), $urandom);
                if ($urandom_range(0, 4) == 0) drain();
            end
            drain();
        end

        // reset while a LATENCY=3 read is waiting
        op(1'b1, 1'b0, BASE + 32'h10, 4'hF, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q1.delete(); g_q1.delete();
        sel = 1'b1; req = 1'b1;
        @(negedge clk);
        check("gnt_in_reset", 64'(gnt3), 64'd0);
        @(posedge clk); #1;
        req = 1'b0;
        rst = 1'b0;
        chained = 0;
        @(negedge clk);
        check("state_after_reset", 64'(st3), 64'(IDLE));
        repeat (6) @(posedge clk);
        #1;
        op(1'b1, 1'b0, BASE + 32'h20, 4'hF, 32'h0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
